level_meter: RTL and testbench

LEVEL_METER -- requirements
Module: level_meter

---
 rtl/level_pkg.sv | 21 ++
 rtl/level_chan.sv | 46 ++++
 rtl/level_meter.sv | 65 ++++++
 tb/tb_level_meter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared constants and the sample-magnitude helper for the four-channel level meter.
package level_pkg;

  localparam int MAG_W                = 7;
  localparam int LVL_W                = 4;
  localparam int NUM_CH               = 4;
  localparam int DECAY_FRAMES_DEFAULT = 4;

  // |sample| in 7 bits; -128 has no positive 8-bit twin, so it saturates to 127.
  function automatic logic [MAG_W-1:0] magnitude(input logic [7:0] smp);
    logic [7:0] neg;
    neg = ~smp + 8'd1;
    if (smp == 8'h80)
      magnitude = '1;
    else if (smp[7])
      magnitude = neg[MAG_W-1:0];
    else
      magnitude = smp[MAG_W-1:0];
  endfunction

endpackage

// File: rtl/level_chan.sv
// One meter channel: per-frame peak accumulator plus the published display level.
module level_chan #(
  parameter int LVL_W = level_pkg::LVL_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ena,
  input  logic                       sel,
  input  logic [level_pkg::MAG_W-1:0] mag,
  input  logic                       frame_tick,
  input  logic                       decay_step,
  output logic [LVL_W-1:0]           level
);
  import level_pkg::*;

  logic [MAG_W-1:0] acc;
  logic [LVL_W-1:0] fresh;
  logic [LVL_W-1:0] next_level;

  assign fresh = acc[MAG_W-1 -: LVL_W];

  // fresh < level implies level > 0, so the decrement can never wrap.
  always_comb begin
    next_level = level;
    if (fresh >= level)
      next_level = fresh;
    else if (decay_step)
      next_level = level - LVL_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc   <= '0;
      level <= '0;
    end else if (ena) begin
      if (frame_tick) begin
        level <= next_level;
        // A sample landing on the tick opens the next frame instead of closing this one.
        acc   <= sel ? mag : '0;
      end else if (sel && (mag > acc)) begin
        acc <= mag;
      end
    end
  end

endmodule

// File: rtl/level_meter.sv
// Four-channel audio peak meter publishing frame-stable bar levels with slow decay.
module level_meter #(
  parameter int DECAY_FRAMES = level_pkg::DECAY_FRAMES_DEFAULT,
  parameter int LVL_W        = level_pkg::LVL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ena,
  input  logic             sample_valid,
  input  logic [1:0]       sample_ch,
  input  logic [7:0]       sample,
  input  logic             frame_tick,
  output logic [LVL_W-1:0] s1,
  output logic [LVL_W-1:0] s2,
  output logic [LVL_W-1:0] s3,
  output logic [LVL_W-1:0] s4
);
  import level_pkg::*;

  localparam logic [3:0] DCNT_LAST = 4'(DECAY_FRAMES - 1);

  logic [MAG_W-1:0]  mag;
  logic [3:0]        dcnt;
  logic              decay_step;
  logic [NUM_CH-1:0] sel;
  logic [LVL_W-1:0]  levels [NUM_CH];

  assign mag        = magnitude(sample);
  assign decay_step = (dcnt == DCNT_LAST);

  always_comb begin
    sel = '0;
    if (sample_valid)
      sel[sample_ch] = 1'b1;
  end

  // Shared frame counter: every channel decays on the same tick.
  always_ff @(posedge clock) begin
    if (reset)
      dcnt <= '0;
    else if (ena && frame_tick)
      dcnt <= decay_step ? 4'd0 : dcnt + 4'd1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    level_chan #(
      .LVL_W(LVL_W)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .ena        (ena),
      .sel        (sel[i]),
      .mag        (mag),
      .frame_tick (frame_tick),
      .decay_step (decay_step),
      .level      (levels[i])
    );
  end

  assign s1 = levels[0];
  assign s2 = levels[1];
  assign s3 = levels[2];
  assign s4 = levels[3];

endmodule

// File: tb/tb_level_meter.sv
// Scoreboard bench for level_meter: two instances (decay every 4 frames and every frame).
module tb_level_meter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic       sample_valid = 1'b0;
  logic [1:0] sample_ch = 2'd0;
  logic [7:0] sample = 8'd0;
  logic       frame_tick = 1'b0;
  logic [3:0] a1, a2, a3, a4;
  logic [3:0] b1, b2, b3, b4;

  int total = 0;
  int bad = 0;
  bit mon_on = 1'b0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] held0 = '0;
  logic [15:0] held1 = '0;

  int m_peak [2][4];
  int m_lvl  [2][4];
  int m_dcnt [2];
  int df     [2] = '{4, 1};

  always #5 clock = ~clock;

  level_meter #(.DECAY_FRAMES(4)) dut_df4 (
    .clock(clock), .reset(reset), .ena(ena), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample(sample), .frame_tick(frame_tick),
    .s1(a1), .s2(a2), .s3(a3), .s4(a4)
  );

  level_meter #(.DECAY_FRAMES(1)) dut_df1 (
    .clock(clock), .reset(reset), .ena(ena), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample(sample), .frame_tick(frame_tick),
    .s1(b1), .s2(b2), .s3(b3), .s4(b4)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int absMag(input int smp);
    int m;
    m = (smp < 0) ? -smp : smp;
    return (m > 127) ? 127 : m;
  endfunction

  function automatic logic [15:0] packLevels(input int d);
    return {4'(m_lvl[d][3]), 4'(m_lvl[d][2]), 4'(m_lvl[d][1]), 4'(m_lvl[d][0])};
  endfunction

  // Reference model: frame peaks, published levels and the frame counter per instance.
  task automatic modelStep(input bit r, input bit e, input bit v, input int ch,
                           input int smp, input bit t);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int c = 0; c < 4; c++) begin
          m_peak[d][c] = 0;
          m_lvl[d][c]  = 0;
        end
        m_dcnt[d] = 0;
      end else if (e && t) begin
        for (int c = 0; c < 4; c++) begin
          int nw;
          nw = m_peak[d][c] / 8;
          if (nw >= m_lvl[d][c])
            m_lvl[d][c] = nw;
          else if (m_dcnt[d] == df[d] - 1 && m_lvl[d][c] > 0)
            m_lvl[d][c] = m_lvl[d][c] - 1;
          m_peak[d][c] = 0;
        end
        m_dcnt[d] = (m_dcnt[d] + 1) % df[d];
        if (v)
          m_peak[d][ch] = absMag(smp);
      end else if (e && v) begin
        if (absMag(smp) > m_peak[d][ch])
          m_peak[d][ch] = absMag(smp);
      end
    end
    if (r || (e && t)) begin
      exp_q0.push_back(packLevels(0));
      exp_q1.push_back(packLevels(1));
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit v, input int ch,
                               input int smp, input bit t);
    @(negedge clock);
    reset        = r;
    ena          = e;
    sample_valid = v;
    sample_ch    = 2'(ch);
    sample       = 8'(smp);
    frame_tick   = t;
    mon_on       = 1'b1;
    @(posedge clock);
    modelStep(r, e, v, ch, smp, t);
    #1;
  endtask

  // Monitor: a publish event pops a new expectation, otherwise outputs must hold.
  always begin
    @(posedge clock);
    #1;
    if (mon_on) begin
      if (exp_q0.size() > 0)
        held0 = exp_q0.pop_front();
      if (exp_q1.size() > 0)
        held1 = exp_q1.pop_front();
      checkOutput("levels_df4", int'({a4, a3, a2, a1}), int'(held0));
      checkOutput("levels_df1", int'({b4, b3, b2, b1}), int'(held1));
    end
  end

  initial begin
    int exp30 [8] = '{12, 12, 11, 11, 11, 11, 10, 10};

    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 2, 100, 1);
    checkOutput("reset_s1", int'(a1), 0);
    checkOutput("reset_s3", int'(a3), 0);

    applyStimulus(0, 1, 1, 0, 40, 0);
    applyStimulus(0, 1, 1, 1, -100, 0);
    applyStimulus(0, 1, 1, 2, -128, 0);
    applyStimulus(0, 1, 1, 3, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("publish_s1", int'(a1), 5);
    checkOutput("publish_s2", int'(a2), 12);
    checkOutput("publish_s3", int'(a3), 15);
    checkOutput("publish_s4", int'(a4), 0);

    for (int t = 1; t <= 20; t++) begin
      applyStimulus(0, 1, 0, 0, 0, 1);
      if (t <= 8)
        checkOutput("decay4_s2", int'(a2), exp30[t-1]);
      checkOutput("decay1_s3", int'(b3), (15 - t > 0) ? 15 - t : 0);
    end
    checkOutput("decay4_s1_floor", int'(a1), 0);

    applyStimulus(0, 1, 1, 0, 127, 1);
    checkOutput("tick_sample_s1", int'(a1), 0);
    checkOutput("tick_sample_df1_s1", int'(b1), 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("next_frame_s1", int'(a1), 15);
    checkOutput("next_frame_df1_s1", int'(b1), 15);

    for (int i = 0; i < 10; i++)
      applyStimulus(0, 0, 1, 3, 120, i == 5);
    checkOutput("ena_low_s4", int'(a4), 0);
    checkOutput("ena_low_s1", int'(a1), 15);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("ena_low_dropped_s4", int'(a4), 0);

    applyStimulus(0, 1, 1, 1, 90, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 16, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("mid_reset_s2", int'(a2), 2);
    checkOutput("mid_reset_df1_s2", int'(b2), 2);

    for (int i = 0; i < 3000; i++) begin
      int smp;
      smp = int'($urandom_range(0, 255)) - 128;
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) < 6, int'($urandom_range(0, 3)), smp,
                    $urandom_range(0, 11) == 0);
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("queue_drained", exp_q0.size() + exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
